hash_state_accum: RTL
=====================

Name: hash_state_accum

Overview:
Parametrised chaining-value accumulator for the SHA-2 family. It holds H0..H(N-1), which are loaded from the IV at message start. After each compressed block it folds the round engine's working variables into H using per-lane modulo-2^WORD_W addition. This extends single-block digesting to multi-block messages and to SHA-512 widths. It sits between the round engine and the output/host interface and presents the final digest with a valid/ready handshake.

Parameters:
WORD_W, 32, lane width in bits (32 = SHA-224/256, 64 = SHA-384/512).
NUM_WORDS, 8, number of chaining lanes.
IV, SHA-256 IV {6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19}, WORD_W*NUM_WORDS bits, lane 0 in the MSBs.

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous reset, active-low.
i_start  in  1  pulse: begin a new message, load IV into H.
i_blk_done  in  1  pulse: i_work is valid and the block compression is finished.
i_last  in  1  qualifies i_blk_done: this block is the final block of the message.
i_work  in  WORD_W*NUM_WORDS  working variables a..h, with a in the MSBs.
o_state  out  WORD_W*NUM_WORDS  current H, used by the round engine to initialise the next block.
o_busy  out  1  high from the accepted i_start until the digest is accepted.
o_hash  out  WORD_W*NUM_WORDS  final digest {H0..H(N-1)}.
o_vld  out  1  digest valid.
i_rdy  in  1  downstream accepts o_hash when o_vld and i_rdy are both high.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - H = IV, o_state = IV.
  - o_hash = 0, o_vld = 0, o_busy = 0.
  - FSM goes to IDLE.
  - Reset takes effect in any state and aborts any message in progress.
- FSM states:
  - IDLE: o_busy=0. On i_start: H<=IV, go to ACCUM. i_blk_done is ignored in IDLE.
  - ACCUM: o_busy=1. On i_blk_done: H[k] <= (H[k] + W[k]) mod 2^WORD_W for every lane k. Carry out of each lane is discarded; no end-around correction. Then:
    - if i_last=0, stay in ACCUM;
    - if i_last=1, go to OUT and load o_hash with the updated H on the same edge.
  - OUT: o_vld=1, o_busy=1, and o_hash is held stable. On o_vld and i_rdy: o_vld<=0, go to IDLE. H is retained so o_state still shows the last digest.
- Latency:
  - The H update appears one cycle after the i_blk_done edge.
  - o_vld rises on the cycle after the final i_blk_done.
  - Back-to-back i_blk_done on consecutive cycles must be accepted, with each fold using the H from the previous fold.
- Simultaneous events:
  - i_start with i_blk_done in ACCUM: i_start wins. H<=IV, the block is discarded, stay in ACCUM.
  - i_start in OUT: ignored until the handshake completes.
  - i_start on the same cycle as the accepting i_rdy: ignored. A new message needs i_start while in IDLE.
- o_hash changes only on the transition into OUT; it is never updated mid-message.
- o_state = H at all times (registered, no combinational path from i_work).
- Width rule: all arithmetic is exactly WORD_W bits per lane, with no cross-lane carry.

Optional Feature:
Macro HASH_BLKCNT_EN.
- Defined: adds output o_blk_cnt (16 bits).
  - Reset to 0; cleared on an accepted i_start.
  - Increments on each accepted i_blk_done in ACCUM; saturates at 16'hFFFF.
  - Held through OUT and IDLE.
- Undefined: the port and the counter do not exist, and all other behaviour is identical.

Test Plan:
1. Reset, then i_start, then one i_blk_done with i_last=1, using the "abc" SHA-256 working vars -> o_hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; o_vld=1 exactly one cycle after i_blk_done.
2. Two-block message "abcdbcdecdefdefg...nopq" (i_last=0, then i_last=1) -> o_hash = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; o_vld stays 0 after block 1.
3. Lane overflow: IV lane 0 = FFFFFFFF, W lane 0 = 00000002 -> H0 = 00000001 (no subtract-FFFFFFFF error); all other lanes are independent.
4. Hold o_vld with i_rdy=0 for 10 cycles while pulsing i_start and i_blk_done -> o_hash is stable and H is unchanged; raise i_rdy -> o_vld drops next cycle and FSM is in IDLE.
5. Reset asserted mid-ACCUM after one block -> o_state = IV and o_busy = 0 next cycle; a new message then produces the correct digest.
6. WORD_W=64 with the SHA-512 IV, single "abc" block -> o_hash = ddaf35a193617aba...a54ca49f (full 512-bit vector); with HASH_BLKCNT_EN, o_blk_cnt = 1 (and 2 for test 2).

Source files
------------

// File: rtl/hash_state_accum.sv
// hash_state_accum: SHA-2 chaining-value accumulator (H <- H + work per lane) with a valid/ready digest port.
// Optional HASH_BLKCNT_EN adds o_blk_cnt, a saturating count of blocks folded into the current message.
module hash_state_accum #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter logic [WORD_W*NUM_WORDS-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19}
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_blk_done,
    input  logic                        i_last,
    input  logic [WORD_W*NUM_WORDS-1:0] i_work,
    output logic [WORD_W*NUM_WORDS-1:0] o_state,
    output logic                        o_busy,
    output logic [WORD_W*NUM_WORDS-1:0] o_hash,
    output logic                        o_vld,
    input  logic                        i_rdy
`ifdef HASH_BLKCNT_EN
    ,
    output logic [15:0]                 o_blk_cnt
`endif
);
    localparam int W = WORD_W * NUM_WORDS;
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   h_q, h_d, hash_q, hash_d, sum;
    logic           load_iv, fold;
    // Each lane wraps independently; carries never cross lane boundaries.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_lane
        assign sum[k*WORD_W +: WORD_W] = h_q[k*WORD_W +: WORD_W] + i_work[k*WORD_W +: WORD_W];
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            h_q     <= IV;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            hash_q  <= hash_d;
        end
    end
    always_comb begin
        state_d = state_q == IDLE  ? (i_start ? ACCUM : IDLE) :
                  state_q == ACCUM ? ((!i_start && i_blk_done && i_last) ? OUT : ACCUM) :
                  state_q == OUT   ? (i_rdy ? IDLE : OUT) : IDLE;
    end
    // i_start beats a same-cycle block; OUT ignores both until the handshake.
    always_comb begin
        load_iv = i_start && (state_q == IDLE || state_q == ACCUM);
        fold    = state_q == ACCUM && i_blk_done && !i_start;
        h_d     = load_iv ? IV : fold ? sum : h_q;
        hash_d  = (fold && i_last) ? sum : hash_q;
    end
    always_comb begin
        o_vld  = state_q == OUT;
        o_busy = state_q != IDLE;
    end
    assign o_state = h_q;
    assign o_hash  = hash_q;
`ifdef HASH_BLKCNT_EN
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load_iv ? 16'd0 : (fold && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign o_blk_cnt = cnt_q;
`endif
endmodule
